img_fetch_stream: RTL and testbench

Parametrised BRAM image-fetch engine: on a start request it reads a ROWS×COLS frame of DATA_W-bit pixels from a single-port block RAM in raster order and presents them as a valid/ready pixel stream with frame/line markers. It sits between the BRAM and the preprocessing stage. It supersedes the fixed-size, fixed-latency memory controller by adding configurable frame geometry, BRAM read latency, base address and downstream backpressure through a credit-controlled skid FIFO.

---
 rtl/img_fetch_if.sv | 34 +++
 rtl/img_fetch_stream.sv | 90 +++++++++
 tb/tb_img_fetch_stream.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/img_fetch_if.sv
// img_fetch_if: control, BRAM and pixel-stream signals of img_fetch_stream
interface img_fetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int ROW_W = 10,
  parameter int COL_W = 10
);
  logic fetch_run_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic busy_o;
  logic fetch_done_o;
  logic ena_o;
  logic wea_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] mem2d_i;
  logic [DATA_W-1:0] data_o;
  logic valid_o;
  logic ready_i;
  logic sof_o;
  logic eol_o;
  logic eof_o;
  logic [ROW_W-1:0] cnt_img_row_o;
  logic [COL_W-1:0] cnt_img_col_o;
  modport master (
    input fetch_run_i, base_addr_i, mem2d_i, ready_i,
    output busy_o, fetch_done_o, ena_o, wea_o, addr_o, data_o, valid_o,
    output sof_o, eol_o, eof_o, cnt_img_row_o, cnt_img_col_o
  );
  modport slave (
    output fetch_run_i, base_addr_i, mem2d_i, ready_i,
    input busy_o, fetch_done_o, ena_o, wea_o, addr_o, data_o, valid_o,
    input sof_o, eol_o, eof_o, cnt_img_row_o, cnt_img_col_o
  );
endinterface

// File: rtl/img_fetch_stream.sv
// img_fetch_stream: credit-controlled BRAM frame reader producing a raster pixel stream with markers
module img_fetch_stream #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int ROWS = 540,
  parameter int COLS = 540,
  parameter int RD_LAT = 1,
  parameter int ROW_W = ROWS > 1 ? $clog2(ROWS) : 1,
  parameter int COL_W = COLS > 1 ? $clog2(COLS) : 1
) (
  input logic clk,
  input logic rst,
  img_fetch_if.master bus
);
  localparam int N = ROWS * COLS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [IW-1:0] idx;
  logic [RD_LAT-1:0] tag;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0] count, inflight;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic issue, push, pop, valid, last_col, last_row;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 4'(tag[i]);
  end
  assign valid = count != '0;
  assign pop = valid && bus.ready_i;
  assign push = tag[RD_LAT-1];
  assign issue = state == FETCH && inflight + count - 4'(pop) < 4'(DEPTH);
  assign last_col = col == COL_W'(COLS - 1);
  assign last_row = row == ROW_W'(ROWS - 1);
  always_comb begin
    state_n = state == IDLE  ? (bus.fetch_run_i ? FETCH : IDLE) :
              state == FETCH ? (issue && idx == IW'(N - 1) ? DRAIN : FETCH) :
              state == DRAIN ? (pop && last_row && last_col ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      idx <= '0;
      tag <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      row <= '0;
      col <= '0;
    end else begin
      state <= state_n;
      tag <= RD_LAT'({tag, issue});
      count <= count + 4'(push) - 4'(pop);
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      if (issue) idx <= idx + IW'(1);
      if (pop) begin
        col <= last_col ? '0 : col + COL_W'(1);
        if (last_col) row <= last_row ? '0 : row + ROW_W'(1);
      end
      if (state == IDLE && bus.fetch_run_i) begin
        base <= bus.base_addr_i;
        idx <= '0;
        row <= '0;
        col <= '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.mem2d_i;
  end
  assign bus.ena_o = issue;
  assign bus.wea_o = 1'b0;
  assign bus.addr_o = issue ? base + ADDR_W'(idx) : '0;
  assign bus.valid_o = valid;
  assign bus.data_o = valid ? mem[rd_ptr] : '0;
  assign bus.sof_o = valid && row == '0 && col == '0;
  assign bus.eol_o = valid && last_col;
  assign bus.eof_o = valid && last_row && last_col;
  assign bus.busy_o = state == FETCH || state == DRAIN;
  assign bus.fetch_done_o = state == DONE;
  assign bus.cnt_img_row_o = row;
  assign bus.cnt_img_col_o = col;
endmodule

// File: tb/tb_img_fetch_stream.sv
// tb_img_fetch_stream: scoreboard bench for a 3x4 frame at read latencies 1 and 3
module tb_img_fetch_stream;
  localparam int N = 12;
  typedef struct packed {
    logic [7:0] d;
    logic sof, eol, eof;
    logic [1:0] row, col;
  } px_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  px_t exp_q[$];
  logic [18:0] addr_q[$];
  int issued = 0, popped = 0, b_iss = 0, b_pop = 0;
  logic prev_eof = 1'b0;
  logic [7:0] pa;
  logic [7:0] pb [3];
  always #5 clk = ~clk;
  img_fetch_if #(.DATA_W(8), .ADDR_W(19), .ROW_W(2), .COL_W(2)) a ();
  img_fetch_if #(.DATA_W(8), .ADDR_W(19), .ROW_W(2), .COL_W(2)) b ();
  img_fetch_stream #(.DATA_W(8), .ADDR_W(19), .ROWS(3), .COLS(4), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a.master));
  img_fetch_stream #(.DATA_W(8), .ADDR_W(19), .ROWS(3), .COLS(4), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(b.master));
  always @(posedge clk) if (a.ena_o) pa <= a.addr_o[7:0];
  assign a.mem2d_i = pa;
  always @(posedge clk) begin
    pb[0] <= b.addr_o[7:0];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign b.mem2d_i = pb[2];
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bad(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask
  task automatic push_frame(logic [18:0] base);
    for (int i = 0; i < N; i++) begin
      logic [18:0] ad;
      px_t p;
      ad = base + 19'(i);
      p = {ad[7:0], i == 0, i % 4 == 3, i == 11, 2'(i / 4), 2'(i % 4)};
      addr_q.push_back(ad);
      exp_q.push_back(p);
    end
  endtask
  task automatic start_a(logic [18:0] base);
    @(negedge clk);
    a.base_addr_i = base;
    a.fetch_run_i = 1'b1;
    push_frame(base);
    @(posedge clk);
    #1 a.fetch_run_i = 1'b0;
  endtask
  task automatic wait_done_a(int limit);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!a.fetch_done_o && cyc < limit);
    if (!a.fetch_done_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no fetch_done_o expected one within %0d cycles", limit);
    end
  endtask
  initial begin
    a.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1 a.ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      issued = 0;
      popped = 0;
      prev_eof = 1'b0;
    end else begin
      if (a.ena_o) begin
        issued++;
        if (addr_q.size() == 0) bad("addr_unexpected");
        else chk("addr", int'(a.addr_o), int'(addr_q.pop_front()));
      end
      if (a.valid_o) begin
        if (exp_q.size() == 0) bad("pixel_unexpected");
        else begin
          chk("pixel", int'({a.data_o, a.sof_o, a.eol_o, a.eof_o, a.cnt_img_row_o, a.cnt_img_col_o}), int'(exp_q[0]));
          if (a.ready_i) void'(exp_q.pop_front());
        end
        if (a.ready_i) popped++;
      end
      if (a.ena_o) chk("occupancy_le3", int'(issued - popped <= 3), 1);
      if (a.fetch_done_o || prev_eof) chk("done_pulse", int'(a.fetch_done_o), int'(prev_eof));
      prev_eof = a.valid_o && a.ready_i && a.eof_o;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      b_iss = 0;
      b_pop = 0;
    end else begin
      if (b.ena_o) b_iss++;
      if (b.valid_o && b.ready_i) b_pop++;
      if (b.ena_o) chk("b_occupancy_le5", int'(b_iss - b_pop <= 5), 1);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end
  initial begin
    int cyc;
    a.fetch_run_i = 1'b0;
    a.base_addr_i = '0;
    b.fetch_run_i = 1'b0;
    b.base_addr_i = '0;
    b.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", int'({a.ena_o, a.wea_o, a.valid_o, a.sof_o, a.eol_o, a.eof_o, a.busy_o, a.fetch_done_o, a.cnt_img_row_o, a.cnt_img_col_o}), 0);
    chk("reset_addr_data", int'({a.addr_o, a.data_o}), 0);
    start_a(19'h100);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("ena_cycle1", int'(a.ena_o), 1);
        chk("busy_cycle1", int'(a.busy_o), 1);
      end
    end while (!a.valid_o && cyc < 50);
    chk("first_valid_cycle", cyc, 3);
    do begin
      @(negedge clk);
      cyc++;
    end while (!a.fetch_done_o && cyc < 50);
    chk("done_cycle", cyc, 15);
    @(negedge clk);
    chk("done_one_cycle", int'({a.fetch_done_o, a.busy_o}), 0);
    rnd = 1'b1;
    start_a(19'h100);
    wait_done_a(400);
    rnd = 1'b0;
    chk("random_queue_empty", exp_q.size(), 0);
    start_a(19'h000);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(a.valid_o && a.cnt_img_row_o == 2'd1 && a.cnt_img_col_o == 2'd2) && cyc < 50);
    chk("reached_pixel6", int'(a.valid_o), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ctrl", int'({a.ena_o, a.wea_o, a.valid_o, a.sof_o, a.eol_o, a.eof_o, a.busy_o, a.fetch_done_o, a.cnt_img_row_o, a.cnt_img_col_o}), 0);
    chk("midrst_addr_data", int'({a.addr_o, a.data_o}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_stale_valid", int'({a.valid_o, a.busy_o}), 0);
    start_a(19'h100);
    wait_done_a(50);
    start_a(19'h7FFFB);
    wait_done_a(50);
    chk("wrap_queue_empty", addr_q.size() + exp_q.size(), 0);
    @(negedge clk);
    a.base_addr_i = 19'h100;
    a.fetch_run_i = 1'b1;
    push_frame(19'h100);
    push_frame(19'h100);
    wait_done_a(50);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(a.valid_o && a.sof_o) && cyc < 50);
    chk("b2b_sof_gap", cyc, 4);
    a.fetch_run_i = 1'b0;
    wait_done_a(50);
    repeat (8) @(negedge clk);
    chk("no_third_frame", int'({a.busy_o, a.valid_o}), 0);
    chk("b2b_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    b.base_addr_i = 19'h100;
    b.fetch_run_i = 1'b1;
    @(posedge clk);
    #1 b.fetch_run_i = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!b.valid_o && cyc < 50);
    chk("b_first_valid_cycle", cyc, 5);
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      chk("b_stream", int'({b.valid_o, b.data_o}), 256 + i);
    end
    @(negedge clk);
    chk("b_done", int'(b.fetch_done_o), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
